avalon_pkt_guard: RTL and testbench
===================================

# avalon_pkt_guard

Store-and-forward packet guard placed directly upstream of the bubble-sort packet block. It accepts an arbitrary Avalon-ST stream and buffers exactly one packet. It forwards only well-formed packets of 1..MAX_PKT_LEN beats to the sorter and silently discards malformed traffic (orphan beats, restarted packets, overlength packets). The sorter is therefore guaranteed clean sop/eop framing and a length it can hold.

## Interface
- DWIDTH, 10, data beat width in bits
- MAX_PKT_LEN, 10, maximum beats per forwarded packet (>=1)
- clk_i  in  1  clock, all logic on rising edge
- srst_i  in  1  reset, asynchronous, active-high
- snk_data_i  in  DWIDTH  upstream data
- snk_startofpacket_i  in  1  upstream sop
- snk_endofpacket_i  in  1  upstream eop
- snk_valid_i  in  1  upstream valid
- snk_ready_o  out  1  guard can accept a beat
- src_data_o  out  DWIDTH  data to sorter
- src_startofpacket_o  out  1  sop to sorter
- src_endofpacket_o  out  1  eop to sorter
- src_valid_o  out  1  beat valid to sorter
- src_ready_i  in  1  sorter ready
- drop_o  out  1  one-cycle pulse per discarded packet/orphan run
- drop_cnt_o  out  16  saturating count of drop_o pulses

## Operation
- Storage: MAX_PKT_LEN x DWIDTH register array; write pointer/length and read pointer of width $clog2(MAX_PKT_LEN+1).
- Accept = snk_valid_i && snk_ready_o. snk_ready_o = 1 in IDLE, RECV, DROP; 0 in SEND and while srst_i is high.
- States: IDLE, RECV, DROP, SEND.
- IDLE: accepted sop beat -> write mem[0], wr_ptr=1; if eop on the same beat, then len=1 -> SEND; else -> RECV. Accepted non-sop beat -> discard, stay in IDLE, drop_o pulse only if that beat carries eop.
- RECV, accepted beat:
  - sop -> previous partial packet dropped (drop_o); write mem[0], wr_ptr=1; eop on the same beat -> SEND.
  - non-sop, wr_ptr==MAX_PKT_LEN (overlength) -> drop_o; eop on the same beat -> IDLE, else -> DROP.
  - otherwise write mem[wr_ptr], wr_ptr+1; eop -> len=wr_ptr+1, SEND.
- DROP: discard beats until an accepted eop beat -> IDLE. An accepted sop beat in DROP starts a new packet exactly as in IDLE.
- SEND: src_valid_o=1, src_data_o=mem[rd_ptr], src_startofpacket_o=(rd_ptr==0), src_endofpacket_o=(rd_ptr==len-1). On src_ready_i, rd_ptr+1; on the eop handshake, rd_ptr=0 -> IDLE.
- Outside SEND: src_valid_o, src_startofpacket_o, src_endofpacket_o = 0; src_data_o = 0.
- drop_cnt_o increments on each drop_o pulse and saturates at 16'hFFFF.

## Timing
- Reset (asynchronous assert): state=IDLE, wr_ptr=rd_ptr=len=0, drop_o=0, drop_cnt_o=0, all src_* outputs=0, snk_ready_o=0. Storage contents are don't-care.
- Reset mid-packet (RECV or SEND) aborts the packet with no drop_o pulse. Beats presented while srst_i is high are ignored.
- Latency: eop accepted in cycle N -> src_valid_o=1 with sop in cycle N+1. Output beats are registered/Moore, with no combinational path from snk_* to src_*.
- Throughput: one output beat per cycle while src_ready_i=1. src_ready_i=0 holds data/sop/eop stable.
- Return to IDLE: the cycle after the eop handshake, snk_ready_o=1 again. Minimum turnaround is 1 cycle between packets.
- drop_o is registered: it is high in the cycle after the offending accept.
- Single-beat packet (sop&eop): src_startofpacket_o and src_endofpacket_o are both 1 on the same beat.
- Exactly MAX_PKT_LEN beats is legal. MAX_PKT_LEN+1 beats is dropped whole.

## Test plan
- Reset then 4-beat packet {3,1,7,2}, src_ready_i=1 -> output {3,1,7,2}; sop on beat 0, eop on beat 3; first output in the cycle after input eop; drop_cnt_o=0.
- 10-beat packet (MAX_PKT_LEN=10) with src_ready_i toggling 1/0 each cycle -> all 10 beats forwarded in order, held stable while stalled; snk_ready_o=0 throughout SEND.
- 11-beat packet -> nothing forwarded; drop_o pulses once; drop_cnt_o=1; next 2-beat packet {5,6} forwarded correctly.
- Orphan beats (no sop, eop on the third), then sop mid-packet restart: {9,8} then sop {1,2,3,eop} -> only {1,2,3} forwarded; drop_cnt_o=2.
- Single-beat packet 0x3FF with sop&eop -> one output beat with sop=eop=1, data 0x3FF.
- Assert srst_i during SEND beat 2 of 5 -> outputs 0 immediately (asynchronous); after release, a new packet {4} is forwarded; drop_cnt_o=0.

Source files
------------

// File: rtl/avalon_pkt_guard.sv
// avalon_pkt_guard: store-and-forward guard passing only well-formed 1..MAX_PKT_LEN beat packets
module avalon_pkt_guard #(
  parameter int DWIDTH      = 10,
  parameter int MAX_PKT_LEN = 10
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              drop_o,
  output logic [15:0]       drop_cnt_o
);
  localparam int PW = $clog2(MAX_PKT_LEN + 1);
  typedef enum logic [1:0] {IDLE, RECV, DROP, SEND} state_t;
  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, len_q, len_d, rd_ptr_q, rd_ptr_d, waddr;
  logic              drop_q, drop_d, we, acc, last, sop, eop;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [DWIDTH-1:0] mem_q [MAX_PKT_LEN];
  assign snk_ready_o = !srst_i && state_q != SEND;
  assign acc  = snk_valid_i && snk_ready_o;
  assign sop  = snk_startofpacket_i;
  assign eop  = snk_endofpacket_i;
  assign last = rd_ptr_q == len_q - 1'b1;
  // framing FSM: capture, discard or replay the buffered packet
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = 1'b0;
    we       = 1'b0;
    waddr    = wr_ptr_q;
    if (state_q == SEND) begin
      if (src_ready_i) begin
        rd_ptr_d = last ? '0 : rd_ptr_q + 1'b1;
        state_d  = last ? IDLE : SEND;
      end
    end else if (acc) begin
      if (sop) begin
        we       = 1'b1;
        waddr    = '0;
        wr_ptr_d = PW'(1);
        drop_d   = state_q == RECV;
        len_d    = eop ? PW'(1) : len_q;
        state_d  = eop ? SEND : RECV;
      end else if (state_q == RECV) begin
        if (wr_ptr_q == PW'(MAX_PKT_LEN)) begin
          drop_d  = 1'b1;
          state_d = eop ? IDLE : DROP;
        end else begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          len_d    = eop ? wr_ptr_q + 1'b1 : len_q;
          state_d  = eop ? SEND : RECV;
        end
      end else begin
        drop_d  = state_q == IDLE && eop;
        state_d = eop ? IDLE : state_q;
      end
    end
  end
  // saturating drop counter advances on each drop pulse
  always_comb drop_cnt_d = (drop_q && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  // control state registers
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      len_q      <= '0;
      rd_ptr_q   <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      len_q      <= len_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  // packet storage, contents need no reset
  always_ff @(posedge clk_i) begin
    if (we) mem_q[waddr] <= snk_data_i;
  end
  assign src_valid_o         = state_q == SEND;
  assign src_data_o          = src_valid_o ? mem_q[rd_ptr_q] : '0;
  assign src_startofpacket_o = src_valid_o && rd_ptr_q == '0;
  assign src_endofpacket_o   = src_valid_o && last;
  assign drop_o              = drop_q;
  assign drop_cnt_o          = drop_cnt_q;
endmodule

// File: tb/tb_avalon_pkt_guard.sv
// tb_avalon_pkt_guard: table-driven packets with scoreboard checking of forwarded beats
module tb_avalon_pkt_guard;
  logic        clk_i = 1'b0, srst_i = 1'b0;
  logic [9:0]  snk_data_i = '0;
  logic        snk_startofpacket_i = 1'b0, snk_endofpacket_i = 1'b0, snk_valid_i = 1'b0;
  logic        snk_ready_o;
  logic [9:0]  src_data_o;
  logic        src_startofpacket_o, src_endofpacket_o, src_valid_o;
  logic        src_ready_i = 1'b1;
  logic        drop_o;
  logic [15:0] drop_cnt_o;
  avalon_pkt_guard #(.DWIDTH(10), .MAX_PKT_LEN(10)) dut (
    .clk_i(clk_i), .srst_i(srst_i),
    .snk_data_i(snk_data_i), .snk_startofpacket_i(snk_startofpacket_i),
    .snk_endofpacket_i(snk_endofpacket_i), .snk_valid_i(snk_valid_i), .snk_ready_o(snk_ready_o),
    .src_data_o(src_data_o), .src_startofpacket_o(src_startofpacket_o),
    .src_endofpacket_o(src_endofpacket_o), .src_valid_o(src_valid_o), .src_ready_i(src_ready_i),
    .drop_o(drop_o), .drop_cnt_o(drop_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct packed {
    logic [15:0][9:0] d;
    logic [15:0]      sop;
    logic [15:0]      eop;
    int               n;
    int               fs;
    int               fn;
    int               drops;
    bit               tog;
  } vec_t;
  vec_t        vt [9];
  logic [11:0] exp_q [$];
  int          checks = 0, errors = 0, drop_seen = 0;
  bit          tog_mode = 1'b0, held = 1'b0;
  logic [11:0] held_v;
  function automatic void chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic vec_t mk(input int n, input logic [15:0] s, input logic [15:0] e,
                              input int fs, input int fn, input int drops, input bit tog);
    vec_t v;
    v = '0;
    v.n = n; v.sop = s; v.eop = e; v.fs = fs; v.fn = fn; v.drops = drops; v.tog = tog;
    return v;
  endfunction
  // sink ready pattern: steady or alternating, changed just after each rising edge
  always @(posedge clk_i) begin
    #1;
    src_ready_i = tog_mode ? ~src_ready_i : 1'b1;
  end
  // output monitor: scoreboard pops, stall stability, sink backpressure in SEND, drop pulses
  always @(negedge clk_i) begin
    if (srst_i) held = 1'b0;
    else begin
      if (drop_o) drop_seen++;
      if (held) begin
        chk(src_valid_o, "valid_held", src_valid_o, 1);
        chk({src_startofpacket_o, src_endofpacket_o, src_data_o} == held_v, "stall_stable",
            {src_startofpacket_o, src_endofpacket_o, src_data_o}, held_v);
        held = 1'b0;
      end
      if (src_valid_o) begin
        chk(!snk_ready_o, "snk_ready_in_send", snk_ready_o, 0);
        if (src_ready_i) begin
          if (exp_q.size() == 0) chk(1'b0, "unexpected_beat", src_data_o, -1);
          else begin
            logic [11:0] e;
            e = exp_q.pop_front();
            chk({src_startofpacket_o, src_endofpacket_o, src_data_o} == e, "beat",
                {src_startofpacket_o, src_endofpacket_o, src_data_o}, e);
          end
        end else begin
          held = 1'b1;
          held_v = {src_startofpacket_o, src_endofpacket_o, src_data_o};
        end
      end
    end
  end
  task automatic drive_beat(input logic [9:0] d, input bit s, input bit e);
    int t;
    t = 0;
    @(negedge clk_i);
    snk_valid_i = 1'b1; snk_data_i = d; snk_startofpacket_i = s; snk_endofpacket_i = e;
    while (!snk_ready_o && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 300) chk(snk_ready_o, "ready_timeout", snk_ready_o, 1);
    @(posedge clk_i);
  endtask
  task automatic drive_idle();
    @(negedge clk_i);
    snk_valid_i = 1'b0; snk_data_i = '0; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0;
  endtask
  task automatic run_vec(input vec_t v);
    int t;
    tog_mode = v.tog;
    for (int k = 0; k < v.fn; k++) exp_q.push_back({k == 0, k == v.fn - 1, v.d[v.fs + k]});
    for (int b = 0; b < v.n; b++) drive_beat(v.d[b], v.sop[b], v.eop[b]);
    drive_idle();
    if (v.fn > 0) begin
      chk(src_valid_o && src_startofpacket_o, "latency_sop", {src_valid_o, src_startofpacket_o}, 3);
      chk(!snk_ready_o, "snk_ready_low", snk_ready_o, 0);
    end
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
    repeat (3) @(negedge clk_i);
    chk(drop_cnt_o == 16'(v.drops), "drop_cnt", drop_cnt_o, v.drops);
    chk(drop_seen == v.drops, "drop_pulses", drop_seen, v.drops);
    chk(snk_ready_o, "snk_ready_idle", snk_ready_o, 1);
  endtask
  initial begin
    vec_t r;
    int t;
    vt[0] = mk(4, 16'h0001, 16'h0008, 0, 4, 0, 1'b0);
    vt[0].d[0] = 10'd3; vt[0].d[1] = 10'd1; vt[0].d[2] = 10'd7; vt[0].d[3] = 10'd2;
    vt[1] = mk(10, 16'h0001, 16'h0200, 0, 10, 0, 1'b1);
    for (int i = 0; i < 10; i++) vt[1].d[i] = 10'(100 + i);
    vt[2] = mk(11, 16'h0001, 16'h0400, 0, 0, 1, 1'b0);
    for (int i = 0; i < 11; i++) vt[2].d[i] = 10'(200 + i);
    vt[3] = mk(2, 16'h0001, 16'h0002, 0, 2, 1, 1'b0);
    vt[3].d[0] = 10'd5; vt[3].d[1] = 10'd6;
    vt[4] = mk(8, 16'h0028, 16'h0084, 5, 3, 3, 1'b0);
    vt[4].d[0] = 10'd20; vt[4].d[1] = 10'd21; vt[4].d[2] = 10'd22; vt[4].d[3] = 10'd9;
    vt[4].d[4] = 10'd8; vt[4].d[5] = 10'd1; vt[4].d[6] = 10'd2; vt[4].d[7] = 10'd3;
    vt[5] = mk(1, 16'h0001, 16'h0001, 0, 1, 3, 1'b0);
    vt[5].d[0] = 10'h3FF;
    vt[6] = mk(3, 16'h0002, 16'h0004, 1, 2, 3, 1'b0);
    vt[6].d[0] = 10'd30; vt[6].d[1] = 10'd31; vt[6].d[2] = 10'd32;
    vt[7] = mk(12, 16'h0001, 16'h0800, 0, 0, 4, 1'b0);
    for (int i = 0; i < 12; i++) vt[7].d[i] = 10'(300 + i);
    vt[8] = mk(1, 16'h0001, 16'h0001, 0, 1, 4, 1'b1);
    vt[8].d[0] = 10'd7;
    #1 srst_i = 1'b1;
    #1;
    chk(!src_valid_o && !src_startofpacket_o && !src_endofpacket_o && src_data_o == '0, "reset_src",
        {src_valid_o, src_startofpacket_o, src_endofpacket_o, src_data_o}, 0);
    chk(!snk_ready_o, "reset_snk_ready", snk_ready_o, 0);
    chk(drop_cnt_o == '0 && !drop_o, "reset_drop", {drop_o, drop_cnt_o}, 0);
    repeat (2) @(negedge clk_i);
    srst_i = 1'b0;
    for (int i = 0; i < 9; i++) run_vec(vt[i]);
    tog_mode = 1'b0;
    for (int k = 0; k < 5; k++) exp_q.push_back({k == 0, k == 4, 10'(40 + k)});
    for (int b = 0; b < 5; b++) drive_beat(10'(40 + b), b == 0, b == 4);
    drive_idle();
    t = 0;
    while (exp_q.size() != 3 && t < 50) begin
      @(posedge clk_i);
      t++;
    end
    chk(exp_q.size() == 3, "pre_reset_progress", exp_q.size(), 3);
    #2 srst_i = 1'b1;
    #1;
    chk(!src_valid_o && !src_startofpacket_o && !src_endofpacket_o && src_data_o == '0, "async_reset_src",
        {src_valid_o, src_startofpacket_o, src_endofpacket_o, src_data_o}, 0);
    chk(!snk_ready_o, "async_reset_snk_ready", snk_ready_o, 0);
    chk(drop_cnt_o == '0, "async_reset_drop_cnt", drop_cnt_o, 0);
    exp_q.delete();
    drop_seen = 0;
    repeat (2) @(negedge clk_i);
    srst_i = 1'b0;
    r = mk(1, 16'h0001, 16'h0001, 0, 1, 0, 1'b0);
    r.d[0] = 10'd4;
    run_vec(r);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
